// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, encodings and the decoded control word for the MIPS multi-cycle controller.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;

   localparam int WAIT_W = 4;

   typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_OR = 2'b11} alu_op_e;
   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_e;
   typedef enum logic [2:0] {K_ALU, K_LW, K_SW, K_BEQ, K_J} kind_e;

   typedef struct packed {
      logic    reg_dst;
      logic    alu_src;
      logic    mem_to_reg;
      alu_op_e alu_cntrl;
      kind_e   kind;
   } ctrl_word_t;

endpackage

// File: rtl/mips_ctrl_fsm_if.sv
// Fetch-unit / datapath side bus of the controller; master = fetch side, slave = controller.
interface mips_ctrl_fsm_if;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] Instructions;
   logic        Zero;
   logic        RegDst, ALUsrc, MemToReg;
   logic        RegWr, MemWr;
   logic [1:0]  ALUcntrl;
   logic        Branch, Jump;
   logic        pc_en;
   logic        illegal;
   logic        busy;

   modport master (
      output instr_valid, Instructions, Zero,
      input  instr_ready, RegDst, ALUsrc, MemToReg, RegWr, MemWr, ALUcntrl,
             Branch, Jump, pc_en, illegal, busy
   );

   modport slave (
      input  instr_valid, Instructions, Zero,
      output instr_ready, RegDst, ALUsrc, MemToReg, RegWr, MemWr, ALUcntrl,
             Branch, Jump, pc_en, illegal, busy
   );
endinterface

// File: rtl/mips_ctrl_decode.sv
// Combinational opcode/funct decoder producing the control word and an illegal flag.
// j (000010) decodes only when MIPS_CTRL_JUMP_EN is defined.
module mips_ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output ctrl_word_t cw,
   output logic       ill
);

   always_comb begin
      cw  = '0;
      ill = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            cw.reg_dst = 1'b1;
            case (funct)
               FN_ADD:  cw.alu_cntrl = ALU_ADD;
               FN_SUB:  cw.alu_cntrl = ALU_SUB;
               FN_AND:  cw.alu_cntrl = ALU_AND;
               FN_OR:   cw.alu_cntrl = ALU_OR;
               default: ill = 1'b1;
            endcase
         end
         OP_ADDI: cw.alu_src = 1'b1;
         OP_LW: begin
            cw.alu_src    = 1'b1;
            cw.mem_to_reg = 1'b1;
            cw.kind       = K_LW;
         end
         OP_SW: begin
            cw.alu_src = 1'b1;
            cw.kind    = K_SW;
         end
         OP_BEQ: begin
            cw.alu_cntrl = ALU_SUB;
            cw.kind      = K_BEQ;
         end
`ifdef MIPS_CTRL_JUMP_EN
         OP_J:    cw.kind = K_J;
`else
         OP_J:    ill = 1'b1;
`endif
         default: ill = 1'b1;
      endcase
      // an illegal word drives no selects at all
      if (ill) cw = '0;
   end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: FETCH->DECODE->EXEC->MEM->WB with MEM wait counter.
// Optional macro MIPS_CTRL_JUMP_EN enables the j instruction and the Jump output.
module mips_ctrl_fsm
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_WAIT = 0
) (
   input  logic            clk,
   input  logic            rst,
   mips_ctrl_fsm_if.slave  bus
);

   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_WAIT);

   state_e            state_q, state_d;
   logic [5:0]        op_q, op_d, fn_q, fn_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              illegal_q, illegal_d;

   ctrl_word_t cw;
   logic       dec_ill;
   logic       active, mem_last;
   logic       ready, reg_wr, mem_wr, branch, pc_en;
`ifdef MIPS_CTRL_JUMP_EN
   logic       jump;
`endif

   mips_ctrl_decode u_dec (
      .opcode (op_q),
      .funct  (fn_q),
      .cw     (cw),
      .ill    (dec_ill)
   );

   assign mem_last = (wait_q == '0);

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      fn_d      = fn_q;
      wait_d    = wait_q;
      illegal_d = illegal_q;
      ready     = 1'b0;
      reg_wr    = 1'b0;
      mem_wr    = 1'b0;
      branch    = 1'b0;
      pc_en     = 1'b0;
`ifdef MIPS_CTRL_JUMP_EN
      jump      = 1'b0;
`endif
      case (state_q)
         S_FETCH: begin
            ready = 1'b1;
            if (bus.instr_valid) begin
               op_d    = bus.Instructions[31:26];
               fn_d    = bus.Instructions[5:0];
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (dec_ill) begin
               illegal_d = 1'b1;
               pc_en     = 1'b1;
               state_d   = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (cw.kind)
               K_ALU: state_d = S_WB;
               K_LW, K_SW: begin
                  wait_d  = WAIT_INIT;
                  state_d = S_MEM;
               end
               K_BEQ: begin
                  branch  = 1'b1;
                  pc_en   = 1'b1;
                  state_d = S_FETCH;
               end
`ifdef MIPS_CTRL_JUMP_EN
               K_J: begin
                  jump    = 1'b1;
                  pc_en   = 1'b1;
                  state_d = S_FETCH;
               end
`endif
               default: state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            if (!mem_last) begin
               wait_d = wait_q - 1'b1;
            end else if (cw.kind == K_SW) begin
               mem_wr  = 1'b1;
               pc_en   = 1'b1;
               state_d = S_FETCH;
            end else begin
               state_d = S_WB;
            end
         end
         S_WB: begin
            reg_wr  = 1'b1;
            pc_en   = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         op_q      <= '0;
         fn_q      <= '0;
         wait_q    <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         fn_q      <= fn_d;
         wait_q    <= wait_d;
         illegal_q <= illegal_d;
      end
   end

   // every output is forced low while rst is high, so an aborted write never fires
   assign active = (state_q != S_FETCH) && !rst;

   assign bus.instr_ready = ready & ~rst;
   assign bus.busy        = active;
   assign bus.RegDst      = cw.reg_dst & active;
   assign bus.ALUsrc      = cw.alu_src & active;
   assign bus.MemToReg    = cw.mem_to_reg & active;
   assign bus.ALUcntrl    = active ? cw.alu_cntrl : 2'b00;
   assign bus.RegWr       = reg_wr & ~rst;
   assign bus.MemWr       = mem_wr & ~rst;
   assign bus.Branch      = branch & ~rst;
   assign bus.pc_en       = pc_en & ~rst;
   assign bus.illegal     = illegal_q & ~rst;
`ifdef MIPS_CTRL_JUMP_EN
   assign bus.Jump        = jump & ~rst;
`else
   assign bus.Jump        = 1'b0;
`endif

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Randomized scoreboard bench for mips_ctrl_fsm: driver pushes model expectations,
// a negedge monitor measures each instruction from handshake to pc_en and compares.
module tb_mips_ctrl_fsm;

   localparam int MW = 2;
`ifdef MIPS_CTRL_JUMP_EN
   localparam bit JEN = 1'b1;
`else
   localparam bit JEN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mips_ctrl_fsm_if bus();

   mips_ctrl_fsm #(.MEM_WAIT(MW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int         lat;
      bit         regwr, memwr, br, jp, ill;
      logic [4:0] mux;
      logic [4:0] mask;
   } exp_t;

   exp_t sbq[$];
   exp_t e_m;
   int   checks = 0;
   int   passes = 0;
   logic [5:0] fns [4] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101};

   function automatic void chk(string name, bit ok, int act, int req);
      checks++;
      if (ok) passes++;
      else $display("FAIL %s: got %0d, want %0d", name, act, req);
   endfunction

   // Expected behaviour straight from the instruction rules; mux = {RegDst,ALUsrc,MemToReg,ALUcntrl}
   function automatic exp_t model(logic [31:0] w);
      exp_t e;
      logic [5:0] op, fn;
      op = w[31:26];
      fn = w[5:0];
      e = '{lat: 2, regwr: 0, memwr: 0, br: 0, jp: 0, ill: 1, mux: 5'b0, mask: 5'b0};
      case (op)
         6'b000000: begin
            for (int i = 0; i < 4; i++)
               if (fn == fns[i]) begin
                  e = '{lat: 4, regwr: 1, memwr: 0, br: 0, jp: 0, ill: 0,
                        mux: {3'b100, 2'(i)}, mask: 5'b11011};
               end
         end
         6'b001000: e = '{lat: 4, regwr: 1, memwr: 0, br: 0, jp: 0, ill: 0, mux: 5'b01000, mask: 5'b11011};
         6'b100011: e = '{lat: 5 + MW, regwr: 1, memwr: 0, br: 0, jp: 0, ill: 0, mux: 5'b01100, mask: 5'b01100};
         6'b101011: e = '{lat: 4 + MW, regwr: 0, memwr: 1, br: 0, jp: 0, ill: 0, mux: 5'b01000, mask: 5'b01000};
         6'b000100: e = '{lat: 3, regwr: 0, memwr: 0, br: 1, jp: 0, ill: 0, mux: 5'b00001, mask: 5'b01011};
         6'b000010: if (JEN) e = '{lat: 3, regwr: 0, memwr: 0, br: 0, jp: 1, ill: 0, mux: 5'b0, mask: 5'b0};
         default: ;
      endcase
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int k;
      w = $urandom;
      k = $urandom_range(0, 9);
      case (k)
         0, 8, 9: begin w[31:26] = 6'b000000; w[5:0] = fns[$urandom_range(0, 3)]; end
         1: w[31:26] = 6'b000000;
         2: w[31:26] = 6'b001000;
         3: w[31:26] = 6'b100011;
         4: w[31:26] = 6'b101011;
         5: w[31:26] = 6'b000100;
         6: w[31:26] = 6'b000010;
         default: ;
      endcase
      return w;
   endfunction

   task automatic issue(input logic [31:0] w);
      bit ok;
      ok = 1'b0;
      @(posedge clk); #1;
      bus.instr_valid  = 1'b1;
      bus.Instructions = w;
      bus.Zero         = 1'($urandom_range(0, 1));
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.instr_ready) begin ok = 1'b1; break; end
      end
      chk("handshake_wait", ok, int'(ok), 1);
      @(posedge clk); #1;
      bus.instr_valid  = 1'b0;
      bus.Instructions = $urandom;
      bus.Zero         = 1'($urandom_range(0, 1));
      if (ok) sbq.push_back(model(w));
   endtask

   // monitor state for the instruction in flight
   bit         act = 1'b0;
   bit         ill_exp = 1'b0;
   int         cyc, n_rw, at_rw, n_mw, at_mw, n_br, at_br, n_jp, at_jp;
   logic [4:0] mux2, mux_now;
   bit         mux_var, busy_bad;

   always @(negedge clk) begin
      mux_now = {bus.RegDst, bus.ALUsrc, bus.MemToReg, bus.ALUcntrl};
      if (rst) begin
         chk("reset_outputs",
             {mux_now, bus.RegWr, bus.MemWr, bus.Branch, bus.Jump, bus.pc_en,
              bus.instr_ready, bus.illegal, bus.busy} == 13'b0,
             int'({mux_now, bus.RegWr, bus.MemWr, bus.Branch, bus.Jump, bus.pc_en,
                   bus.instr_ready, bus.illegal, bus.busy}), 0);
         act     = 1'b0;
         ill_exp = 1'b0;
         sbq.delete();
      end else if (act) begin
         cyc++;
         if (bus.RegWr)  begin n_rw++; at_rw = cyc; end
         if (bus.MemWr)  begin n_mw++; at_mw = cyc; end
         if (bus.Branch) begin n_br++; at_br = cyc; end
         if (bus.Jump)   begin n_jp++; at_jp = cyc; end
         if (cyc == 2) mux2 = mux_now;
         else if (mux_now != mux2) mux_var = 1'b1;
         if (bus.busy !== 1'b1) busy_bad = 1'b1;
         if (bus.pc_en) begin
            if (sbq.size() == 0) begin
               chk("unexpected_retire", 1'b0, cyc, 0);
            end else begin
               e_m = sbq.pop_front();
               chk("pc_en_latency", cyc == e_m.lat, cyc, e_m.lat);
               chk("regwr_count*100+cycle", n_rw == int'(e_m.regwr) && (!e_m.regwr || at_rw == e_m.lat),
                   n_rw * 100 + at_rw, e_m.regwr ? 100 + e_m.lat : 0);
               chk("memwr_count*100+cycle", n_mw == int'(e_m.memwr) && (!e_m.memwr || at_mw == e_m.lat),
                   n_mw * 100 + at_mw, e_m.memwr ? 100 + e_m.lat : 0);
               chk("branch_count*100+cycle", n_br == int'(e_m.br) && (!e_m.br || at_br == 3),
                   n_br * 100 + at_br, e_m.br ? 103 : 0);
               chk("jump_count*100+cycle", n_jp == int'(e_m.jp) && (!e_m.jp || at_jp == 3),
                   n_jp * 100 + at_jp, e_m.jp ? 103 : 0);
               chk("mux_selects", ((mux2 ^ e_m.mux) & e_m.mask) == 5'b0 && !mux_var,
                   int'(mux2), int'(e_m.mux));
               chk("busy_in_flight", !busy_bad, int'(busy_bad), 0);
               chk("illegal_flag", bus.illegal == ill_exp, int'(bus.illegal), int'(ill_exp));
               ill_exp = ill_exp | e_m.ill;
            end
            act = 1'b0;
         end else if (cyc > 40) begin
            chk("retire_timeout", 1'b0, cyc, 40);
            act = 1'b0;
         end
      end else begin
         // idle FETCH: only instr_ready and the sticky illegal may be high
         chk("idle_outputs",
             {bus.instr_ready, bus.busy, mux_now, bus.RegWr, bus.MemWr, bus.Branch, bus.Jump,
              bus.pc_en, bus.illegal} == {1'b1, 1'b0, 5'b0, 5'b0, ill_exp},
             int'({bus.instr_ready, bus.busy, mux_now, bus.RegWr, bus.MemWr, bus.Branch, bus.Jump,
                   bus.pc_en, bus.illegal}),
             int'({1'b1, 1'b0, 5'b0, 5'b0, ill_exp}));
         if (bus.instr_valid && bus.instr_ready) begin
            act = 1'b1; cyc = 1;
            n_rw = 0; n_mw = 0; n_br = 0; n_jp = 0;
            at_rw = 0; at_mw = 0; at_br = 0; at_jp = 0;
            mux_var = 1'b0; busy_bad = 1'b0; mux2 = 5'b0;
         end
      end
   end

   initial begin
      bus.instr_valid  = 1'b0;
      bus.Instructions = '0;
      bus.Zero         = 1'b0;
      rst              = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      issue({6'b001000, 5'd0, 5'd1, 16'd2015});             // addi $1,$0,2015
      issue({6'b000000, 5'd1, 5'd2, 5'd1, 5'd0, 6'b100000}); // add  $1,$1,$2
      issue({6'b101011, 5'd0, 5'd2, 16'd0});                // sw   $2,0($0)
      issue({6'b100011, 5'd0, 5'd3, 16'd0});                // lw   $3,0($0)
      issue({6'b000100, 5'd1, 5'd1, 16'd4});                // beq
      issue({6'b000010, 26'h10});                           // j
      issue({6'b111111, 26'h0});                            // unsupported opcode
      issue({6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b000111}); // unsupported funct

      for (int n = 0; n < 150; n++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         issue(rand_instr());
      end

      // reset lands in the first MEM cycle of a lw
      issue({6'b100011, 5'd0, 5'd3, 16'd0});
      @(posedge clk);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post_reset_fetch", bus.instr_ready && !bus.busy && !bus.RegWr,
          int'({bus.instr_ready, bus.busy, bus.RegWr}), 4);
      repeat (10) @(posedge clk);
      issue({6'b001000, 5'd0, 5'd1, 16'd7});

      repeat (20) @(posedge clk);
      chk("scoreboard_drained", sbq.size() == 0, sbq.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
